cpu_run_controller: RTL and testbench
=====================================

CPU_RUN_CONTROLLER -- requirements
Module: cpu_run_controller

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 10, program counter width.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 16, required input stability in clk cycles.
REQ-003 SHALL have parameter RESET_HOLD_CYCLES, default 4, minimum cpu_reset_n low time.
REQ-004 SHALL have parameter COUNT_WIDTH, default 32, cycle_count width.
REQ-005 SHALL have port clk  input  1  sole clock; all logic on posedge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port reset_btn  input  1  raw asynchronous button, high = pressed.
REQ-008 SHALL have port manual_clk_sw  input  1  raw switch, high = manual stepping.
REQ-009 SHALL have port pulse_clk_btn  input  1  raw step button.
REQ-010 SHALL have port halt_req  input  1  CPU executed HALT, sampled only in RUN.
REQ-011 SHALL have port pc  input  PC_WIDTH  current CPU program counter.
REQ-012 SHALL have port cpu_reset_n  output  1  registered active-low CPU reset.
REQ-013 SHALL have port cpu_clk_en  output  1  registered CPU advance enable, one instruction per high cycle.
REQ-014 SHALL have port halted  output  1  registered, high in HALTED.
REQ-015 SHALL have port cycle_count  output  COUNT_WIDTH  enabled CPU cycles since CPU reset.

Function
REQ-016 SHALL pass each raw input through a 2-flop synchronizer, then a debouncer whose output changes only after the synchronized value has differed from it for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count.
REQ-017 SHALL derive one-cycle rise pulses from debounced reset_btn and pulse_clk_btn.
REQ-018 SHALL implement states RESET_HOLD, RUN, MANUAL, HALTED (plus BREAK, see Configuration).
REQ-019 RESET_HOLD: cpu_reset_n=0, cpu_clk_en=0, cycle_count cleared; hold counter reloads while debounced reset_btn high; after RESET_HOLD_CYCLES with button released -> MANUAL if debounced switch high, else RUN.
REQ-020 RUN: cpu_clk_en=1 every cycle; debounced switch high -> MANUAL; halt_req high -> HALTED, cpu_clk_en low from the next cycle.
REQ-021 MANUAL: cpu_clk_en=1 for exactly one cycle per pulse_clk_btn rise pulse; debounced switch low -> RUN.
REQ-022 HALTED: cpu_clk_en=0, halted=1; exits only via reset_btn.
REQ-023 reset_btn rise pulse SHALL force RESET_HOLD from any state, taking priority over all simultaneous events.
REQ-024 halt_req and switch change in the same RUN cycle SHALL go to HALTED.
REQ-025 cycle_count SHALL increment in each cycle cpu_clk_en is high and saturate at all-ones.
REQ-026 With DEBOUNCE_CYCLES=D, a clean step-button press SHALL give its single cpu_clk_en cycle exactly D+4 clk cycles after the raw rising edge.

Reset
REQ-027 reset high SHALL set state RESET_HOLD, all synchronizer, debouncer and counter registers 0, cpu_reset_n=0, cpu_clk_en=0, halted=0, cycle_count=0.
REQ-028 reset SHALL override any in-progress debounce, step or hold count with no output glitch.

Configuration
REQ-029 Macro TURTLE_RUN_CTRL_BREAKPOINT_EN, when defined, SHALL add ports bp_addr (input PC_WIDTH), bp_valid (input 1), bp_hit (output 1) and state BREAK.
REQ-030 With macro: in RUN, bp_valid high and pc==bp_addr -> BREAK, cpu_clk_en low from next cycle; BREAK holds bp_hit=1, cpu_clk_en=0; step rise pulse gives one cpu_clk_en then RUN; switch high -> MANUAL; reset_btn -> RESET_HOLD.
REQ-031 Without macro: the three ports, BREAK state and comparator SHALL be absent; behaviour otherwise identical.

Verification
REQ-032 reset 3 cycles, buttons low, switch low -> cpu_reset_n low 4 cycles after reset release plus debounce settling, then RUN with cpu_clk_en=1 each cycle.
REQ-033 In RUN, 100 cycles then halt_req one cycle -> cycle_count=100, halted=1, cpu_clk_en=0 thereafter.
REQ-034 Switch high, 3 clean step presses (D=16) -> exactly 3 cpu_clk_en cycles, each 20 cycles after the raw edge.
REQ-035 Step button bouncing every 5 cycles for 60 cycles then stable high -> exactly one cpu_clk_en pulse.
REQ-036 reset_btn press while in HALTED and while mid-step -> RESET_HOLD, cycle_count=0, cpu_reset_n low at least 4 cycles.
REQ-037 Macro defined, bp_addr=0x00A, bp_valid=1 -> BREAK at pc=0x00A, bp_hit=1; one step press -> single cpu_clk_en, then RUN.

Source files
------------

// File: rtl/cpu_run_controller.sv
// Run/step/halt controller for the teaching CPU: synchronises and debounces the front-panel
// inputs, sequences CPU reset and gates the CPU clock enable. Optional breakpoint: TURTLE_RUN_CTRL_BREAKPOINT_EN.
module cpu_run_controller #(
  parameter int PC_WIDTH          = 10,
  parameter int DEBOUNCE_CYCLES   = 16,
  parameter int RESET_HOLD_CYCLES = 4,
  parameter int COUNT_WIDTH       = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   reset_btn,
  input  logic                   manual_clk_sw,
  input  logic                   pulse_clk_btn,
  input  logic                   halt_req,
  input  logic [PC_WIDTH-1:0]    pc,
`ifdef TURTLE_RUN_CTRL_BREAKPOINT_EN
  input  logic [PC_WIDTH-1:0]    bp_addr,
  input  logic                   bp_valid,
  output logic                   bp_hit,
`endif
  output logic                   cpu_reset_n,
  output logic                   cpu_clk_en,
  output logic                   halted,
  output logic [COUNT_WIDTH-1:0] cycle_count
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(RESET_HOLD_CYCLES + 1);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD_CYCLES - 1);
  localparam int CH_RST  = 0;
  localparam int CH_SW   = 1;
  localparam int CH_STEP = 2;

  typedef enum logic [2:0] {
    S_RESET_HOLD,
    S_RUN,
    S_MANUAL,
    S_HALTED
`ifdef TURTLE_RUN_CTRL_BREAKPOINT_EN
    , S_BREAK
`endif
  } state_t;

  state_t            state, state_next;
  logic [2:0]        raw_in, sync1, sync2, deb, deb_q;
  logic [DB_W-1:0]   db_cnt [3];
  logic              rst_rise, step_rise;
  logic [HOLD_W-1:0] hold_cnt, hold_next;
  logic              en_next;

  assign raw_in = {pulse_clk_btn, manual_clk_sw, reset_btn};

  // A debounced output flips only after the synchronised input has disagreed with it
  // for DEBOUNCE_CYCLES cycles in a row; agreement at any point restarts the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1     <= '0;
      sync2     <= '0;
      deb       <= '0;
      deb_q     <= '0;
      rst_rise  <= 1'b0;
      step_rise <= 1'b0;
      for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      sync1     <= raw_in;
      sync2     <= sync1;
      deb_q     <= deb;
      rst_rise  <= deb[CH_RST] & ~deb_q[CH_RST];
      step_rise <= deb[CH_STEP] & ~deb_q[CH_STEP];
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          deb[i]    <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

`ifdef TURTLE_RUN_CTRL_BREAKPOINT_EN
  logic bp_match;
  assign bp_match = bp_valid && (pc == bp_addr);
`else
  logic unused_pc;
  assign unused_pc = ^pc;
`endif

  always_comb begin
    state_next = state;
    hold_next  = hold_cnt;
    en_next    = 1'b0;
    if (rst_rise) begin
      state_next = S_RESET_HOLD;
      hold_next  = '0;
    end else begin
      case (state)
        S_RESET_HOLD: begin
          if (deb[CH_RST]) begin
            hold_next = '0;
          end else if (hold_cnt == HOLD_LAST) begin
            hold_next = '0;
            if (deb[CH_SW]) begin
              state_next = S_MANUAL;
            end else begin
              state_next = S_RUN;
              en_next    = 1'b1;
            end
          end else begin
            hold_next = hold_cnt + 1'b1;
          end
        end
        S_RUN: begin
          if (halt_req) state_next = S_HALTED;
`ifdef TURTLE_RUN_CTRL_BREAKPOINT_EN
          else if (bp_match) state_next = S_BREAK;
`endif
          else if (deb[CH_SW]) state_next = S_MANUAL;
          else en_next = 1'b1;
        end
        S_MANUAL: begin
          if (!deb[CH_SW]) begin
            state_next = S_RUN;
            en_next    = 1'b1;
          end else begin
            en_next = step_rise;
          end
        end
        S_HALTED: state_next = S_HALTED;
`ifdef TURTLE_RUN_CTRL_BREAKPOINT_EN
        S_BREAK: begin
          if (deb[CH_SW]) begin
            state_next = S_MANUAL;
          end else if (step_rise) begin
            state_next = S_RUN;
            en_next    = 1'b1;
          end
        end
`endif
        default: state_next = S_RESET_HOLD;
      endcase
    end
  end

  // Outputs are registered from the next state so they change cleanly on the clock edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_RESET_HOLD;
      hold_cnt    <= '0;
      cpu_reset_n <= 1'b0;
      cpu_clk_en  <= 1'b0;
      halted      <= 1'b0;
    end else begin
      state       <= state_next;
      hold_cnt    <= hold_next;
      cpu_reset_n <= (state_next != S_RESET_HOLD);
      cpu_clk_en  <= en_next;
      halted      <= (state_next == S_HALTED);
    end
  end

`ifdef TURTLE_RUN_CTRL_BREAKPOINT_EN
  always_ff @(posedge clk) begin
    if (reset) bp_hit <= 1'b0;
    else       bp_hit <= (state_next == S_BREAK);
  end
`endif

  always_ff @(posedge clk) begin
    if (reset || state_next == S_RESET_HOLD) begin
      cycle_count <= '0;
    end else if (cpu_clk_en && cycle_count != '1) begin
      cycle_count <= cycle_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_cpu_run_controller.sv
// Self-checking bench for cpu_run_controller: reset sequencing, run/halt, table of mode
// vectors, and a scoreboard of expected step-enable cycles in manual mode.
module tb_cpu_run_controller;

  localparam int D = 16;

  logic        clk;
  logic        reset;
  logic        reset_btn;
  logic        manual_clk_sw;
  logic        pulse_clk_btn;
  logic        halt_req;
  logic [9:0]  pc;
  logic        cpu_reset_n;
  logic        cpu_clk_en;
  logic        halted;
  logic [31:0] cycle_count;
`ifdef TURTLE_RUN_CTRL_BREAKPOINT_EN
  logic [9:0]  bp_addr;
  logic        bp_valid;
  logic        bp_hit;
`endif

  cpu_run_controller #(
    .PC_WIDTH(10), .DEBOUNCE_CYCLES(D), .RESET_HOLD_CYCLES(4), .COUNT_WIDTH(32)
  ) dut (
    .clk(clk),
    .reset(reset),
    .reset_btn(reset_btn),
    .manual_clk_sw(manual_clk_sw),
    .pulse_clk_btn(pulse_clk_btn),
    .halt_req(halt_req),
    .pc(pc),
`ifdef TURTLE_RUN_CTRL_BREAKPOINT_EN
    .bp_addr(bp_addr),
    .bp_valid(bp_valid),
    .bp_hit(bp_hit),
`endif
    .cpu_reset_n(cpu_reset_n),
    .cpu_clk_en(cpu_clk_en),
    .halted(halted),
    .cycle_count(cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic rbtn;
    logic sw;
    logic step;
    logic halt;
    int   cycles;
    logic exp_rstn;
    logic exp_en;
    logic exp_halted;
  } vec_t;

  vec_t vecs [9];
  int   n_vec;
  int   n_fail;
  int   cyc;
  int   en_seen;
  bit   sb_on;
  int   exp_q [$];

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // One clock: sample just after the edge, model the CPU's pc, and score step enables.
  task automatic tick();
    logic en_before;
    en_before = cpu_clk_en;
    @(posedge clk);
    #1;
    cyc++;
    if (cpu_reset_n !== 1'b1) pc = '0;
    else if (en_before === 1'b1) pc = pc + 1'b1;
    if (sb_on) begin
      if (exp_q.size() > 0 && exp_q[0] < cyc) begin
        n_vec++;
        n_fail++;
        $display("[TB] FAIL step_en_missing: got none, expected enable at cycle %0d", exp_q[0]);
        void'(exp_q.pop_front());
      end
      if (cpu_clk_en === 1'b1) begin
        n_vec++;
        if (exp_q.size() > 0 && exp_q[0] == cyc) begin
          void'(exp_q.pop_front());
        end else begin
          n_fail++;
          $display("[TB] FAIL step_en_unexpected: got enable at cycle %0d, expected none", cyc);
        end
      end
    end
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    reset_btn     = v.rbtn;
    manual_clk_sw = v.sw;
    pulse_clk_btn = v.step;
    halt_req      = v.halt;
    repeat (v.cycles) tick();
    halt_req = 1'b0;
    checkOutput($sformatf("vec%0d_rstn", idx), 64'(cpu_reset_n), 64'(v.exp_rstn));
    checkOutput($sformatf("vec%0d_en", idx), 64'(cpu_clk_en), 64'(v.exp_en));
    checkOutput($sformatf("vec%0d_halted", idx), 64'(halted), 64'(v.exp_halted));
  endtask

  task automatic stepPress();
    pulse_clk_btn = 1'b1;
    exp_q.push_back(cyc + D + 4);
    repeat (30) tick();
    pulse_clk_btn = 1'b0;
    repeat (30) tick();
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    n_vec = 0; n_fail = 0; cyc = 0; sb_on = 1'b0;
    reset = 1'b1; reset_btn = 1'b0; manual_clk_sw = 1'b0;
    pulse_clk_btn = 1'b0; halt_req = 1'b0; pc = '0;
`ifdef TURTLE_RUN_CTRL_BREAKPOINT_EN
    bp_addr = '0; bp_valid = 1'b0;
`endif
    //        rbtn sw  step halt cyc rstn en  halted
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0,  4, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 25, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 25, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b1,  2, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 25, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 25, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 25, 1'b1, 1'b0, 1'b1};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 25, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 25, 1'b1, 1'b1, 1'b0};

    repeat (3) tick();
    checkOutput("reset_rstn", 64'(cpu_reset_n), 64'd0);
    checkOutput("reset_en", 64'(cpu_clk_en), 64'd0);
    checkOutput("reset_halted", 64'(halted), 64'd0);
    checkOutput("reset_count", 64'(cycle_count), 64'd0);

    reset = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      checkOutput($sformatf("hold_rstn_%0d", i), 64'(cpu_reset_n), 64'd0);
    end
    tick();
    checkOutput("run_rstn", 64'(cpu_reset_n), 64'd1);
    checkOutput("run_en", 64'(cpu_clk_en), 64'd1);

    en_seen = 1;
    repeat (99) begin
      tick();
      if (cpu_clk_en === 1'b1) en_seen++;
    end
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    checkOutput("halt_halted", 64'(halted), 64'd1);
    checkOutput("halt_en", 64'(cpu_clk_en), 64'd0);
    checkOutput("halt_count", 64'(cycle_count), 64'd100);
    checkOutput("run_en_cycles", 64'(en_seen), 64'd100);
    repeat (5) tick();
    checkOutput("halt_hold_en", 64'(cpu_clk_en), 64'd0);
    checkOutput("halt_hold_count", 64'(cycle_count), 64'd100);

    // reset_btn out of HALTED: takes effect D+4 cycles after the raw edge
    reset_btn = 1'b1;
    repeat (D + 3) tick();
    checkOutput("rbtn_early_rstn", 64'(cpu_reset_n), 64'd1);
    tick();
    checkOutput("rbtn_rstn", 64'(cpu_reset_n), 64'd0);
    checkOutput("rbtn_count", 64'(cycle_count), 64'd0);
    checkOutput("rbtn_halted", 64'(halted), 64'd0);
    repeat (10) tick();
    reset_btn = 1'b0;
    repeat (D + 5) tick();
    checkOutput("release_hold_rstn", 64'(cpu_reset_n), 64'd0);
    tick();
    checkOutput("release_rstn", 64'(cpu_reset_n), 64'd1);
    checkOutput("release_en", 64'(cpu_clk_en), 64'd1);

    for (int i = 0; i < 9; i++) applyStimulus(vecs[i], i);

    // halt and switch resolving in the same RUN cycle must halt
    manual_clk_sw = 1'b1;
    repeat (D + 2) tick();
    checkOutput("coinc_pre_en", 64'(cpu_clk_en), 64'd1);
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    checkOutput("coinc_halted", 64'(halted), 64'd1);
    checkOutput("coinc_en", 64'(cpu_clk_en), 64'd0);

    reset_btn = 1'b1;
    repeat (25) tick();
    reset_btn = 1'b0;
    repeat (25) tick();
    checkOutput("manual_rstn", 64'(cpu_reset_n), 64'd1);
    checkOutput("manual_en", 64'(cpu_clk_en), 64'd0);
    checkOutput("manual_count", 64'(cycle_count), 64'd0);

    sb_on = 1'b1;
    repeat (3) stepPress();
    checkOutput("steps_count", 64'(cycle_count), 64'd3);

    for (int i = 0; i < 12; i++) begin
      pulse_clk_btn = (i % 2 == 0);
      repeat (5) tick();
    end
    stepPress();
    checkOutput("bounce_count", 64'(cycle_count), 64'd4);

    // reset_btn and step arriving together: reset wins, no enable
    reset_btn = 1'b1;
    pulse_clk_btn = 1'b1;
    repeat (D + 3) tick();
    checkOutput("midstep_early_rstn", 64'(cpu_reset_n), 64'd1);
    tick();
    checkOutput("midstep_rstn", 64'(cpu_reset_n), 64'd0);
    checkOutput("midstep_count", 64'(cycle_count), 64'd0);
    repeat (4) tick();
    checkOutput("midstep_hold_rstn", 64'(cpu_reset_n), 64'd0);
    reset_btn = 1'b0;
    pulse_clk_btn = 1'b0;
    repeat (30) tick();
    checkOutput("midstep_after_rstn", 64'(cpu_reset_n), 64'd1);
    checkOutput("midstep_after_en", 64'(cpu_clk_en), 64'd0);
    sb_on = 1'b0;
    checkOutput("sb_drained", 64'(exp_q.size()), 64'd0);

`ifdef TURTLE_RUN_CTRL_BREAKPOINT_EN
    bp_addr = 10'h00A;
    bp_valid = 1'b1;
    manual_clk_sw = 1'b0;
    for (int i = 0; i < 80 && bp_hit !== 1'b1; i++) tick();
    checkOutput("bp_hit", 64'(bp_hit), 64'd1);
    tick();
    checkOutput("bp_en", 64'(cpu_clk_en), 64'd0);
    pulse_clk_btn = 1'b1;
    repeat (D + 3) tick();
    checkOutput("bp_step_early_en", 64'(cpu_clk_en), 64'd0);
    tick();
    checkOutput("bp_step_en", 64'(cpu_clk_en), 64'd1);
    pulse_clk_btn = 1'b0;
    tick();
    checkOutput("bp_run_en", 64'(cpu_clk_en), 64'd1);
    checkOutput("bp_run_hit", 64'(bp_hit), 64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
